// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: NPORTS register-write channels plus a HI/LO bundle, with
// hold/bubble/flush control, same-bundle write-collision resolution and saturating counters.
module mem_wb_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NPORTS  = 2,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned STAGE   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic                     clr_cnt,
  input  logic                     mem_valid,
  input  logic [NPORTS*ADDR_W-1:0] mem_wd,
  input  logic [NPORTS-1:0]        mem_wreg,
  input  logic [NPORTS*DATA_W-1:0] mem_wdata,
  input  logic                     mem_whilo,
  input  logic [DATA_W-1:0]        mem_hi,
  input  logic [DATA_W-1:0]        mem_lo,
  output logic                     wb_valid,
  output logic [NPORTS*ADDR_W-1:0] wb_wd,
  output logic [NPORTS-1:0]        wb_wreg,
  output logic [NPORTS*DATA_W-1:0] wb_wdata,
  output logic                     wb_whilo,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         hold_cnt,
  output logic [CNT_W-1:0]         retire_cnt
);

  typedef enum logic [1:0] {ModeAdvance, ModeHold, ModeBubble} mode_e;

  mode_e             mode;
  logic [NPORTS-1:0] wreg_qual;
  logic [NPORTS-1:0] wreg_res;
  logic              whilo_qual;

  always_comb begin
    mode = ModeAdvance;
    if (flush) begin
      mode = ModeBubble;
    end else if (stall[STAGE]) begin
      mode = stall[STAGE+1] ? ModeHold : ModeBubble;
    end
  end

  // Writes to r0 are dropped; on an address collision the younger (higher-index) port wins.
  always_comb begin
    wreg_qual = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      wreg_qual[p] = mem_valid & mem_wreg[p] & (mem_wd[p*ADDR_W +: ADDR_W] != '0);
    end
    wreg_res = wreg_qual;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      for (int unsigned j = i + 1; j < NPORTS; j++) begin
        if (wreg_qual[i] && wreg_qual[j] &&
            (mem_wd[i*ADDR_W +: ADDR_W] == mem_wd[j*ADDR_W +: ADDR_W])) begin
          wreg_res[i] = 1'b0;
        end
      end
    end
    whilo_qual = mem_valid & mem_whilo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_wd    <= '0;
      wb_wreg  <= '0;
      wb_wdata <= '0;
      wb_whilo <= 1'b0;
      wb_hi    <= '0;
      wb_lo    <= '0;
    end else begin
      unique case (mode)
        ModeBubble: begin
          wb_valid <= 1'b0;
          wb_wd    <= '0;
          wb_wreg  <= '0;
          wb_wdata <= '0;
          wb_whilo <= 1'b0;
          wb_hi    <= '0;
          wb_lo    <= '0;
        end
        ModeAdvance: begin
          wb_valid <= mem_valid;
          wb_wd    <= mem_wd;
          wb_wreg  <= wreg_res;
          wb_wdata <= mem_wdata;
          wb_whilo <= whilo_qual;
          wb_hi    <= mem_hi;
          wb_lo    <= mem_lo;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
      retire_cnt <= '0;
    end else if (clr_cnt) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
      retire_cnt <= '0;
    end else begin
      if (mode == ModeBubble && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
      if (mode == ModeHold && hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
      if (mode == ModeAdvance && mem_valid && retire_cnt != '1) retire_cnt <= retire_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe (NPORTS=2, CNT_W=4): driver pushes hand-derived expectations,
// monitor pops one per clock edge and compares every output.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush, clr_cnt, mem_valid, mem_whilo;
  logic [9:0]  mem_wd;
  logic [1:0]  mem_wreg;
  logic [63:0] mem_wdata;
  logic [31:0] mem_hi, mem_lo;
  logic        wb_valid, wb_whilo;
  logic [9:0]  wb_wd;
  logic [1:0]  wb_wreg;
  logic [63:0] wb_wdata;
  logic [31:0] wb_hi, wb_lo;
  logic [3:0]  bubble_cnt, hold_cnt, retire_cnt;

  mem_wb_pipe #(
    .DATA_W(32), .ADDR_W(5), .NPORTS(2), .STALL_W(6), .STAGE(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
    .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [9:0]  wd;
    logic [1:0]  wreg;
    logic [63:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  bub;
    logic [3:0]  hold;
    logic [3:0]  ret;
  } exp_t;

  exp_t q[$];
  exp_t mdl;
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(e.valid));
    chk({tag, ".wb_wd"}, 64'(wb_wd), 64'(e.wd));
    chk({tag, ".wb_wreg"}, 64'(wb_wreg), 64'(e.wreg));
    chk({tag, ".wb_wdata"}, wb_wdata, e.wdata);
    chk({tag, ".wb_whilo"}, 64'(wb_whilo), 64'(e.whilo));
    chk({tag, ".wb_hi"}, 64'(wb_hi), 64'(e.hi));
    chk({tag, ".wb_lo"}, 64'(wb_lo), 64'(e.lo));
    chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(e.bub));
    chk({tag, ".hold_cnt"}, 64'(hold_cnt), 64'(e.hold));
    chk({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(e.ret));
  endtask

  function automatic logic [3:0] sat_inc(input logic [3:0] c, input logic inc);
    return (inc && c != 4'hF) ? c + 4'd1 : c;
  endfunction

  // mode: "A" advance, "H" hold, "B" bubble -- chosen by hand for each vector.
  task automatic step(input logic [5:0] st, input logic fl, input logic cl, input logic v,
                      input logic [9:0] wd, input logic [1:0] wr, input logic [63:0] wdat,
                      input logic wh, input logic [31:0] hi, input byte mode,
                      input logic [1:0] ewreg, input logic ewh);
    @(negedge clk);
    stall = st; flush = fl; clr_cnt = cl; mem_valid = v; mem_wd = wd; mem_wreg = wr;
    mem_wdata = wdat; mem_whilo = wh; mem_hi = hi; mem_lo = hi ^ 32'hA5A5_A5A5;
    if (mode == "A") begin
      mdl.valid = v; mdl.wd = wd; mdl.wreg = ewreg; mdl.wdata = wdat;
      mdl.whilo = ewh; mdl.hi = hi; mdl.lo = hi ^ 32'hA5A5_A5A5;
    end else if (mode == "B") begin
      mdl.valid = 1'b0; mdl.wd = '0; mdl.wreg = '0; mdl.wdata = '0;
      mdl.whilo = 1'b0; mdl.hi = '0; mdl.lo = '0;
    end
    if (cl) begin
      mdl.bub = '0; mdl.hold = '0; mdl.ret = '0;
    end else begin
      mdl.bub  = sat_inc(mdl.bub, mode == "B");
      mdl.hold = sat_inc(mdl.hold, mode == "H");
      mdl.ret  = sat_inc(mdl.ret, mode == "A" && v);
    end
    q.push_back(mdl);
  endtask

  task automatic idle_inputs();
    stall = '0; flush = 0; clr_cnt = 0; mem_valid = 0; mem_wd = '0; mem_wreg = '0;
    mem_wdata = '0; mem_whilo = 0; mem_hi = '0; mem_lo = '0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check_all("edge", mon_e);
      end
    end
  end

  initial begin
    mdl = '0;
    idle_inputs();
    rst = 1'b1;
    #2;
    check_all("reset", mdl);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    step(6'b000000, 0, 0, 1, {5'd0, 5'd3}, 2'b01, {32'h0, 32'hDEAD_BEEF}, 1, 32'h5, "A", 2'b01, 1);
    step(6'b110000, 0, 0, 1, {5'd9, 5'd9}, 2'b11, 64'h1234, 0, 32'h7, "H", 2'b00, 0);
    step(6'b110000, 0, 0, 0, {5'd1, 5'd8}, 2'b10, 64'h5678, 1, 32'h6, "H", 2'b00, 0);
    step(6'b010000, 0, 0, 1, {5'd1, 5'd2}, 2'b11, 64'hFFFF, 1, 32'h8, "B", 2'b00, 0);
    step(6'b000000, 0, 0, 1, {5'd7, 5'd7}, 2'b11, {32'h22, 32'h11}, 0, 32'h0, "A", 2'b10, 0);
    step(6'b000000, 0, 0, 1, {5'd4, 5'd0}, 2'b11, {32'h44, 32'h33}, 0, 32'h1, "A", 2'b10, 0);
    step(6'b000000, 0, 0, 1, {5'd4, 5'd3}, 2'b11, {32'h66, 32'h55}, 1, 32'h2, "A", 2'b11, 1);
    step(6'b000000, 0, 0, 1, {5'd7, 5'd7}, 2'b01, {32'h88, 32'h77}, 0, 32'h3, "A", 2'b01, 0);
    step(6'b000000, 0, 0, 0, {5'd4, 5'd3}, 2'b11, {32'hAA, 32'h99}, 1, 32'hA, "A", 2'b00, 0);
    step(6'b101111, 0, 0, 1, {5'd2, 5'd1}, 2'b11, {32'hCC, 32'hBB}, 0, 32'hB, "A", 2'b11, 0);
    step(6'b110000, 1, 0, 1, {5'd2, 5'd1}, 2'b11, {32'hEE, 32'hDD}, 1, 32'hC, "B", 2'b00, 0);
    step(6'b000000, 1, 0, 1, {5'd2, 5'd1}, 2'b11, {32'h12, 32'h34}, 1, 32'hD, "B", 2'b00, 0);
    step(6'b000000, 0, 0, 1, {5'd0, 5'd6}, 2'b01, {32'h0, 32'h99}, 1, 32'h5, "A", 2'b01, 1);

    // Asynchronous reset between edges, after the monitor has consumed the last vector.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    mdl = '0;
    check_all("async_reset", mdl);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(6'b000000, 0, 0, 1, {5'd0, 5'd1}, 2'b01, 64'(i), 0, 32'(i), "A", 2'b01, 0);
    end
    step(6'b000000, 0, 1, 1, {5'd2, 5'd1}, 2'b11, 64'h77, 0, 32'h1, "A", 2'b11, 0);
    step(6'b000000, 0, 0, 1, {5'd3, 5'd3}, 2'b11, 64'h78, 1, 32'h2, "A", 2'b10, 1);
    step(6'b110000, 0, 0, 1, {5'd5, 5'd5}, 2'b11, 64'h79, 0, 32'h3, "H", 2'b00, 0);

    @(posedge clk);
    #3;
    chk("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
